// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats and the
// per-opcode control classification used by the decode/issue stage.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic     rs1Used;
        logic     rs2Used;
        logic     rdWen;
        imm_fmt_e immFmt;
    } dec_ctrl_t;

    // Unknown opcodes fall through as NOPs: no reads, no write, zero immediate.
    function automatic dec_ctrl_t decodeCtrl(input logic [6:0] opcode, input logic [4:0] rd);
        dec_ctrl_t c;
        c.rs1Used = 1'b0;
        c.rs2Used = 1'b0;
        c.rdWen   = 1'b0;
        c.immFmt  = IMM_NONE;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                c.rdWen  = 1'b1;
                c.immFmt = IMM_U;
            end
            OP_JAL: begin
                c.rdWen  = 1'b1;
                c.immFmt = IMM_J;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                c.rs1Used = 1'b1;
                c.rdWen   = 1'b1;
                c.immFmt  = IMM_I;
            end
            OP_BRANCH: begin
                c.rs1Used = 1'b1;
                c.rs2Used = 1'b1;
                c.immFmt  = IMM_B;
            end
            OP_STORE: begin
                c.rs1Used = 1'b1;
                c.rs2Used = 1'b1;
                c.immFmt  = IMM_S;
            end
            OP_REG: begin
                c.rs1Used = 1'b1;
                c.rs2Used = 1'b1;
                c.rdWen   = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) begin
            c.rdWen = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; the 32-bit immediate is
// sign-extended to XLEN. Opcode bits are not needed, so only [31:7] come in.
module imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_o = XLEN'(signed'(imm32));
    end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decode, operand read, busy-bit scoreboard and the
// ID/EX register. Define WB_BYPASS_EN to forward writeback data into issue.
module decode_issue
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            rf_rd_en1,
    output logic            rf_rd_en2,
    output logic [4:0]      rf_rd_addr1,
    output logic [4:0]      rf_rd_addr2,
    input  logic [XLEN-1:0] rf_rd_data1,
    input  logic [XLEN-1:0] rf_rd_data2,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_wen,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    dec_ctrl_t       ctrl;
    logic [XLEN-1:0] imm;

    logic [31:0]     busy_q, busy_d;

    logic            exValid_q, exValid_d;
    logic [XLEN-1:0] exPc_q, exPc_d;
    logic [XLEN-1:0] exOpA_q, exOpA_d;
    logic [XLEN-1:0] exOpB_q, exOpB_d;
    logic [XLEN-1:0] exImm_q, exImm_d;
    logic [4:0]      exRd_q, exRd_d;
    logic            exRdWen_q, exRdWen_d;
    logic [6:0]      exOpcode_q, exOpcode_d;
    logic [2:0]      exFunct3_q, exFunct3_d;
    logic            exFunct7b5_q, exFunct7b5_d;

    logic            byp1, byp2;
    logic            hazard;
    logic            stageFree;
    logic            ready;
    logic            issue;
    logic [XLEN-1:0] opA, opB;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign ctrl   = decodeCtrl(opcode, rd);

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i (if_instr[31:7]),
        .fmt_i   (ctrl.immFmt),
        .imm_o   (imm)
    );

`ifdef WB_BYPASS_EN
    // A register being written this cycle is ready: take its value straight from writeback.
    assign byp1 = wb_en && (wb_addr == rs1) && (rs1 != 5'd0);
    assign byp2 = wb_en && (wb_addr == rs2) && (rs2 != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard = if_valid &&
                    ((ctrl.rs1Used && busy_q[rs1] && !byp1) ||
                     (ctrl.rs2Used && busy_q[rs2] && !byp2) ||
                     (ctrl.rdWen   && busy_q[rd]));

    assign stageFree = !exValid_q || ex_ready;
    assign ready     = !hazard && !flush && stageFree;
    assign issue     = if_valid && ready;
    assign if_ready  = ready;

    assign rf_rd_en1   = if_valid && ctrl.rs1Used;
    assign rf_rd_en2   = if_valid && ctrl.rs2Used;
    assign rf_rd_addr1 = ctrl.rs1Used ? rs1 : 5'd0;
    assign rf_rd_addr2 = ctrl.rs2Used ? rs2 : 5'd0;

    assign opA = byp1 ? wb_data : rf_rd_data1;
    assign opB = byp2 ? wb_data : rf_rd_data2;

    // Busy updates apply clears first so that a same-cycle set of the same register wins.
    always_comb begin
        busy_d       = busy_q;
        exValid_d    = exValid_q;
        exPc_d       = exPc_q;
        exOpA_d      = exOpA_q;
        exOpB_d      = exOpB_q;
        exImm_d      = exImm_q;
        exRd_d       = exRd_q;
        exRdWen_d    = exRdWen_q;
        exOpcode_d   = exOpcode_q;
        exFunct3_d   = exFunct3_q;
        exFunct7b5_d = exFunct7b5_q;

        if (wb_en && (wb_addr != 5'd0)) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush && exValid_q && exRdWen_q) begin
            busy_d[exRd_q] = 1'b0;
        end

        if (issue) begin
            exValid_d    = 1'b1;
            exPc_d       = if_pc;
            exOpA_d      = opA;
            exOpB_d      = opB;
            exImm_d      = imm;
            exRd_d       = rd;
            exRdWen_d    = ctrl.rdWen;
            exOpcode_d   = opcode;
            exFunct3_d   = if_instr[14:12];
            exFunct7b5_d = if_instr[30];
            if (ctrl.rdWen) begin
                busy_d[rd] = 1'b1;
            end
        end else if (flush) begin
            exValid_d = 1'b0;
        end else if (exValid_q && ex_ready) begin
            exValid_d = 1'b0;
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            exValid_q    <= 1'b0;
            exPc_q       <= '0;
            exOpA_q      <= '0;
            exOpB_q      <= '0;
            exImm_q      <= '0;
            exRd_q       <= '0;
            exRdWen_q    <= 1'b0;
            exOpcode_q   <= '0;
            exFunct3_q   <= '0;
            exFunct7b5_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            exValid_q    <= exValid_d;
            exPc_q       <= exPc_d;
            exOpA_q      <= exOpA_d;
            exOpB_q      <= exOpB_d;
            exImm_q      <= exImm_d;
            exRd_q       <= exRd_d;
            exRdWen_q    <= exRdWen_d;
            exOpcode_q   <= exOpcode_d;
            exFunct3_q   <= exFunct3_d;
            exFunct7b5_q <= exFunct7b5_d;
        end
    end

    assign ex_valid    = exValid_q;
    assign ex_pc       = exPc_q;
    assign ex_op_a     = exOpA_q;
    assign ex_op_b     = exOpB_q;
    assign ex_imm      = exImm_q;
    assign ex_rd       = exRd_q;
    assign ex_rd_wen   = exRdWen_q;
    assign ex_opcode   = exOpcode_q;
    assign ex_funct3   = exFunct3_q;
    assign ex_funct7b5 = exFunct7b5_q;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_decode_issue;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            rf_rd_en1, rf_rd_en2;
    logic [4:0]      rf_rd_addr1, rf_rd_addr2;
    logic [XLEN-1:0] rf_rd_data1, rf_rd_data2;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_rd_wen;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;

    // Bench-side register file; reads are combinational from the DUT's addresses.
    logic [31:0] regs [32];
    assign rf_rd_data1 = regs[rf_rd_addr1];
    assign rf_rd_data2 = regs[rf_rd_addr2];

    decode_issue #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .rf_rd_en1   (rf_rd_en1),
        .rf_rd_en2   (rf_rd_en2),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_op_a     (ex_op_a),
        .ex_op_b     (ex_op_b),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_rd_wen   (ex_rd_wen),
        .ex_opcode   (ex_opcode),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    typedef struct {
        bit          r1u;
        bit          r2u;
        bit          wen;
        int          rs1;
        int          rs2;
        int          rd;
        logic [31:0] imm;
    } refDec_t;

    // Reference decode: immediates assembled arithmetically from the RV32I field layout.
    function automatic refDec_t refDecode(input logic [31:0] ins);
        refDec_t     d;
        logic [31:0] sgn;
        sgn   = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        d.rd  = int'(ins[11:7]);
        d.rs1 = int'(ins[19:15]);
        d.rs2 = int'(ins[24:20]);
        d.r1u = 0;
        d.r2u = 0;
        d.wen = 0;
        d.imm = 32'h0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                d.wen = 1;
                d.imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                d.wen = 1;
                d.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13: begin
                d.r1u = 1;
                d.wen = 1;
                d.imm = (sgn << 12) | 32'(ins[31:20]);
            end
            7'h23: begin
                d.r1u = 1;
                d.r2u = 1;
                d.imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            end
            7'h63: begin
                d.r1u = 1;
                d.r2u = 1;
                d.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h33: begin
                d.r1u = 1;
                d.r2u = 1;
                d.wen = 1;
            end
            default: ;
        endcase
        if (d.rd == 0) d.wen = 0;
        return d;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [6:0]  ops [10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // Model of the ID/EX register contents and the set of in-flight destinations.
    bit          mValid;
    logic [31:0] mPc, mA, mB, mImm;
    int          mRd;
    bit          mWen;
    logic [6:0]  mOpc;
    logic [2:0]  mF3;
    bit          mF7;
    bit          busy [32];

    task automatic modelReset();
        mValid = 0; mPc = 0; mA = 0; mB = 0; mImm = 0;
        mRd = 0; mWen = 0; mOpc = 0; mF3 = 0; mF7 = 0;
        for (int i = 0; i < 32; i++) busy[i] = 0;
    endtask

    task automatic applyStimulus(input bit rstV, input bit validV, input logic [31:0] instrV,
                                 input logic [31:0] pcV, input bit exRdyV, input bit flV,
                                 input bit wbEnV, input logic [4:0] wbAddrV, input logic [31:0] wbDataV,
                                 output bit issued);
        refDec_t     d;
        bit          byp1, byp2, haz, rdy;
        int          a1, a2;
        logic [31:0] opA, opB;
        @(negedge clk);
        rst = rstV; if_valid = validV; if_instr = instrV; if_pc = pcV;
        ex_ready = exRdyV; flush = flV; wb_en = wbEnV; wb_addr = wbAddrV; wb_data = wbDataV;
        #1;
        d = refDecode(instrV);
        byp1 = 0;
        byp2 = 0;
`ifdef WB_BYPASS_EN
        byp1 = wbEnV && (int'(wbAddrV) == d.rs1) && (d.rs1 != 0);
        byp2 = wbEnV && (int'(wbAddrV) == d.rs2) && (d.rs2 != 0);
`endif
        haz = validV && ((d.r1u && busy[d.rs1] && !byp1) ||
                         (d.r2u && busy[d.rs2] && !byp2) ||
                         (d.wen && busy[d.rd]));
        rdy = !haz && !flV && (!mValid || exRdyV);
        a1  = d.r1u ? d.rs1 : 0;
        a2  = d.r2u ? d.rs2 : 0;
        checkOutput("if_ready", 32'(if_ready), 32'(rdy));
        checkOutput("rf_rd_en1", 32'(rf_rd_en1), 32'(validV && d.r1u));
        checkOutput("rf_rd_en2", 32'(rf_rd_en2), 32'(validV && d.r2u));
        checkOutput("rf_rd_addr1", 32'(rf_rd_addr1), 32'(a1));
        checkOutput("rf_rd_addr2", 32'(rf_rd_addr2), 32'(a2));
        opA = byp1 ? wbDataV : regs[a1];
        opB = byp2 ? wbDataV : regs[a2];
        issued = validV && rdy && !rstV;

        @(posedge clk);
        #1;
        if (wbEnV && wbAddrV != 0) regs[wbAddrV] = wbDataV;
        if (rstV) begin
            modelReset();
        end else begin
            if (wbEnV && wbAddrV != 0) busy[wbAddrV] = 0;
            if (flV && mValid && mWen) busy[mRd] = 0;
            if (issued) begin
                mValid = 1; mPc = pcV; mA = opA; mB = opB; mImm = d.imm;
                mRd = int'(instrV[11:7]); mWen = d.wen; mOpc = instrV[6:0];
                mF3 = instrV[14:12]; mF7 = instrV[30];
                if (d.wen) busy[d.rd] = 1;
            end else if (flV || (mValid && exRdyV)) begin
                mValid = 0;
            end
        end
        checkOutput("ex_valid", 32'(ex_valid), 32'(mValid));
        checkOutput("ex_pc", ex_pc, mPc);
        checkOutput("ex_op_a", ex_op_a, mA);
        checkOutput("ex_op_b", ex_op_b, mB);
        checkOutput("ex_imm", ex_imm, mImm);
        checkOutput("ex_rd", 32'(ex_rd), 32'(mRd));
        checkOutput("ex_rd_wen", 32'(ex_rd_wen), 32'(mWen));
        checkOutput("ex_opcode", 32'(ex_opcode), 32'(mOpc));
        checkOutput("ex_funct3", 32'(ex_funct3), 32'(mF3));
        checkOutput("ex_funct7b5", 32'(ex_funct7b5), 32'(mF7));
    endtask

    initial begin
        bit iss;
        int rawCycles;
        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 0;
        flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        modelReset();

        // Reset state
        applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0, iss);
        applyStimulus(1, 1, 32'h00500093, 32'h0, 0, 1, 0, 5'd0, 32'h0, iss);
        checkOutput("reset_ex_valid", 32'(ex_valid), 32'h0);
        checkOutput("reset_ex_imm", ex_imm, 32'h0);

        // ADDI x1,x0,5
        applyStimulus(0, 1, 32'h00500093, 32'h100, 1, 0, 0, 5'd0, 32'h0, iss);
        checkOutput("addi_ex_valid", 32'(ex_valid), 32'h1);
        checkOutput("addi_ex_rd", 32'(ex_rd), 32'h1);
        checkOutput("addi_ex_imm", ex_imm, 32'h5);
        checkOutput("addi_ex_rd_wen", 32'(ex_rd_wen), 32'h1);

        // ADD x3,x1,x2 stalls on x1; writeback of x1 arrives on the third cycle
`ifdef WB_BYPASS_EN
        rawCycles = 3;
`else
        rawCycles = 4;
`endif
        for (int c = 0; c < rawCycles; c++) begin
            applyStimulus(0, 1, 32'h002081B3, 32'h104, 1, 0, (c == 2), 5'd1, 32'h2A, iss);
        end
        checkOutput("raw_ex_rd", 32'(ex_rd), 32'h3);
        checkOutput("raw_ex_op_a", ex_op_a, 32'h2A);
        checkOutput("raw_ex_valid", 32'(ex_valid), 32'h1);

        // EX back-pressure with ADDI x6 waiting
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, 32'h00700313, 32'h108, 0, 0, 0, 5'd0, 32'h0, iss);
        end
        checkOutput("hold_ex_rd", 32'(ex_rd), 32'h3);
        checkOutput("hold_ex_op_a", ex_op_a, 32'h2A);
        applyStimulus(0, 1, 32'h00700313, 32'h108, 1, 0, 0, 5'd0, 32'h0, iss);

        // ADDI x5 issues, then is flushed while fetch offers another instruction
        applyStimulus(0, 1, 32'h00100293, 32'h10C, 1, 0, 0, 5'd0, 32'h0, iss);
        applyStimulus(0, 1, 32'h00100293, 32'h110, 1, 1, 0, 5'd0, 32'h0, iss);
        checkOutput("flush_ex_valid", 32'(ex_valid), 32'h0);
        applyStimulus(0, 1, 32'h00100293, 32'h110, 1, 0, 0, 5'd0, 32'h0, iss);
        checkOutput("post_flush_ex_pc", ex_pc, 32'h110);

        // WAW on x1
        applyStimulus(0, 1, 32'h00900093, 32'h114, 1, 0, 0, 5'd0, 32'h0, iss);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, 32'h00300093, 32'h118, 1, 0, (c == 2), 5'd1, 32'h11, iss);
        end
        checkOutput("waw_ex_imm", ex_imm, 32'h3);

        // Flush drops x1's busy bit; an old writeback and a new x1 writer coincide
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 0, 5'd0, 32'h0, iss);
        applyStimulus(0, 1, 32'h00400093, 32'h11C, 1, 0, 1, 5'd1, 32'h77, iss);
        applyStimulus(0, 1, 32'h000083B3, 32'h120, 1, 0, 0, 5'd0, 32'h0, iss);
        checkOutput("set_wins_ex_rd", 32'(ex_rd), 32'h1);
        checkOutput("set_wins_ex_valid", 32'(ex_valid), 32'h0);

        // x0 as destination and source
        applyStimulus(0, 1, 32'h00100013, 32'h200, 1, 0, 1, 5'd1, 32'h5, iss);
        checkOutput("x0_ex_rd_wen", 32'(ex_rd_wen), 32'h0);
        applyStimulus(0, 1, 32'h00000233, 32'h204, 1, 0, 0, 5'd0, 32'h0, iss);
        checkOutput("x0_rf_rd_addr1", 32'(rf_rd_addr1), 32'h0);
        checkOutput("x0_ex_rd", 32'(ex_rd), 32'h4);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 3) != 0),
                          randInstr(),
                          $urandom,
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                          $urandom,
                          iss);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Instruction decode and issue stage of the in-order RV32I core, sitting between fetch and execute and driving the register file's two read ports. Decodes each fetched instruction, reads its source operands, generates the immediate and registers everything into the ID/EX pipeline register under a valid/ready handshake. A per-register busy scoreboard stalls issue on RAW and WAW hazards against in-flight writes; the register file's write port is mirrored in to clear busy bits.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rf_rd_en1, rf_rd_en2  out  1  register file read enables
- rf_rd_addr1, rf_rd_addr2  out  5  rs1 and rs2 addresses
- rf_rd_data1, rf_rd_data2  in  XLEN  combinational read data
- wb_en  in  1  register file write enable, same signal as the regfile's wr_en
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data
- flush  in  1  kill the ID/EX contents (taken branch/jump in EX)
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  execute consumes ex_* this cycle
- ex_pc, ex_op_a, ex_op_b, ex_imm  out  XLEN  pc, rs1 value, rs2 value, sign-extended immediate
- ex_rd  out  5  destination register
- ex_rd_wen  out  1  instruction writes ex_rd
- ex_opcode  out  7;  ex_funct3  out  3;  ex_funct7b5  out  1  control fields for EX

## Operation
- Source usage: rs1 used by all formats except LUI, AUIPC, JAL; rs2 used by R, S, B. rf_rd_enN = if_valid & usage; an unused address output drives 0.
- rd write: R, I (ALU, load, JALR), U, J formats with rd != 0. S, B, unknown opcodes: ex_rd_wen = 0, no reads; unknown opcodes issue as NOPs.
- Immediate: I, S, B, U, J formats per RV32I, sign-extended to XLEN; R format imm = 0.
- Scoreboard busy[31:1]; busy[0] is constant 0.
- hazard = if_valid & ((rs1 used & busy[rs1]) | (rs2 used & busy[rs2]) | (rd_wen & busy[rd])).
- issue = if_valid & !hazard & !flush & (!ex_valid | ex_ready); if_ready = !hazard & !flush & (!ex_valid | ex_ready).
- On issue: load all ex_* fields, ex_valid <= 1, busy[rd] <= 1 when rd_wen.
- ex_valid & ex_ready & !issue: ex_valid <= 0, ex_* hold.
- ex_valid & !ex_ready: all ex_* hold stable.
- wb_en & wb_addr != 0: busy[wb_addr] <= 0.
- Same-cycle set and clear of one register: set wins.
- flush: ex_valid <= 0; if ex_valid & ex_rd_wen, busy[ex_rd] <= 0. No issue that cycle. Older instructions beyond EX are not affected and still clear their bits at writeback.

## Timing
- Reset: ex_valid = 0, all ex_* = 0, all busy bits = 0. if_ready is combinational and is 1 in the first cycle after reset when ex_ready or !ex_valid.
- Latency: an instruction accepted at edge N is presented on ex_* after edge N.
- Operands are sampled from rf_rd_data in the issue cycle.
- Dependent instruction behind a producer: stalls until the producer's wb_en cycle.
- Writer to x0 never sets a busy bit; reads of x0 never stall.
- rst asserted mid-stall or mid-handshake: the next cycle starts in the reset state, regardless of flush or ex_ready.

## Configuration
- WB_BYPASS_EN defined: in a cycle with wb_en & wb_addr == rsN != 0, busy[rsN] is ignored for the hazard and ex_op_a/ex_op_b take wb_data. The instruction issues in the writeback cycle.
- Undefined: no bypass. The stall lasts until the cycle after wb_en, when the register file returns the written value. This costs one extra cycle per dependency.

## Structure
- cpu_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG)
  - imm_fmt_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
  - XLEN default
- Sub-module imm_gen: combinational; takes the instruction and imm_fmt_e, returns the XLEN immediate.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with ex_ready=1 -> ex_valid=1 next cycle, ex_rd=1, ex_imm=5, ex_rd_wen=1, busy[1]=1.
- ADD x3,x1,x2 right after x1 issues, wb_en for x1 (wb_data=0x2A) after 3 cycles -> if_ready=0 until the wb cycle; with WB_BYPASS_EN, issue in the wb cycle with ex_op_a=0x2A; without it, issue one cycle later with ex_op_a=0x2A.
- ex_ready=0 for 4 cycles with a valid instruction held -> ex_* stable, if_ready=0, no busy bits change.
- Flush in the cycle after ADDI x5 issues, with if_valid=1 -> ex_valid=0, busy[5]=0, nothing accepted that cycle.
- Second write to x1 while busy[1]=1 -> WAW stall until wb_en for x1. Same cycle as that wb_en, issue of x1 writer -> busy[1] stays 1.
- ADDI x0,x0,1 followed by ADD x4,x0,x0 -> no stall, rf_rd_addr1=rf_rd_addr2=0, ex_rd_wen=0 for the first.
